// File: rtl/rs_latch_driver_pkg.sv
// Shared types and defaults for the RS latch driver: FSM state encoding,
// parameter defaults and the counter width used for pulse/gap/check timing.
package rs_latch_driver_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PULSE = 3'd1,
      GAP   = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int PULSE_W_DEF  = 4;
   localparam int GAP_W_DEF    = 2;
   localparam int CHECK_TO_DEF = 8;
   localparam int CNT_W        = 8;

   // Counters count down to zero, so a phase of N cycles loads N-1.
   function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/rs_latch_driver_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/rs_latch_driver.sv
// Drives width-controlled S/R pulses into a gated RS latch and verifies Q readback.
// Optional macro RS_LATCH_DRIVER_SKIP_EN: skip the pulse when the latch already holds the value.
module rs_latch_driver
   import rs_latch_driver_pkg::*;
#(
   parameter int PULSE_W  = PULSE_W_DEF,
   parameter int GAP_W    = GAP_W_DEF,
   parameter int CHECK_TO = CHECK_TO_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   input  logic req_value,
   output logic req_ready,
   output logic R,
   output logic S,
   input  logic q_fb,
   output logic done,
   output logic err,
   output logic busy
);

   localparam logic [CNT_W-1:0] PULSE_LD = cnt_load(PULSE_W);
   localparam logic [CNT_W-1:0] GAP_LD   = cnt_load(GAP_W);
   localparam logic [CNT_W-1:0] CHECK_LD = cnt_load(CHECK_TO);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             val_q, val_d;
   logic             r_q, r_d;
   logic             s_q, s_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             q_sync;
   logic             accept;
   logic             skip;

   sync_2ff u_q_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (q_fb),
      .q     (q_sync)
   );

   assign accept = req_valid & ready_q;

`ifdef RS_LATCH_DRIVER_SKIP_EN
   assign skip = (q_sync == req_value);
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      r_d     = r_q;
      s_d     = s_q;
      done_d  = 1'b0;
      err_d   = err_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               val_d   = req_value;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               ready_d = 1'b0;
               if (skip) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = PULSE;
                  cnt_d   = PULSE_LD;
                  s_d     = req_value;
                  r_d     = ~req_value;
               end
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               r_d = 1'b0;
               s_d = 1'b0;
               if (GAP_W == 0) begin
                  state_d = CHECK;
                  cnt_d   = CHECK_LD;
               end else begin
                  state_d = GAP;
                  cnt_d   = GAP_LD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               state_d = CHECK;
               cnt_d   = CHECK_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         CHECK: begin
            // Readback is only trusted here; glitches earlier never reach a decision.
            if (q_sync == val_q) begin
               state_d = DONE;
               err_d   = 1'b0;
               done_d  = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = DONE;
               err_d   = 1'b1;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            r_d     = 1'b0;
            s_d     = 1'b0;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         val_q   <= 1'b0;
         r_q     <= 1'b0;
         s_q     <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         r_q     <= r_d;
         s_q     <= s_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   assign R         = r_q;
   assign S         = s_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign req_ready = ready_q;

endmodule

// File: tb/tb_rs_latch_driver.sv
// Scoreboard bench for rs_latch_driver with a behavioural RS latch model.
module tb_rs_latch_driver;

   localparam int PULSE_W  = 4;
   localparam int GAP_W    = 2;
   localparam int CHECK_TO = 8;

   logic clk       = 1'b0;
   logic rst_n     = 1'b0;
   logic req_valid = 1'b0;
   logic req_value = 1'b0;
   logic q_fb;
   logic req_ready, R, S, done, err, busy;

   always #5 clk = ~clk;

   rs_latch_driver #(
      .PULSE_W  (PULSE_W),
      .GAP_W    (GAP_W),
      .CHECK_TO (CHECK_TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_value (req_value),
      .req_ready (req_ready),
      .R         (R),
      .S         (S),
      .q_fb      (q_fb),
      .done      (done),
      .err       (err),
      .busy      (busy)
   );

   // Latch model: responds one cycle after S/R, optionally stuck.
   logic q_model   = 1'b0;
   bit   stuck_en  = 1'b0;
   logic stuck_val = 1'b0;

   always @(posedge clk) begin
      if (stuck_en)  q_model <= stuck_val;
      else if (S)    q_model <= 1'b1;
      else if (R)    q_model <= 1'b0;
   end
   assign q_fb = q_model;

   typedef struct {
      logic err;
      int   lat;
      int   s_cnt;
      int   r_cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   function automatic exp_t mk(input logic er, input int lat, input int sc, input int rc);
      exp_t t;
      t.err = er; t.lat = lat; t.s_cnt = sc; t.r_cnt = rc;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: samples on the falling edge, pops expectations on done.
   int acc_cyc    = -1;
   int s_seen     = 0;
   int r_seen     = 0;
   int first_seen = -1;
   bit after_done = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         acc_cyc    = -1;
         s_seen     = 0;
         r_seen     = 0;
         first_seen = -1;
         after_done = 1'b0;
      end else begin
         if (R && S) begin
            errors++;
            $display("FAIL r_and_s actual=1 required=0 (t=%0t)", $time);
         end
         if (done && req_ready) begin
            errors++;
            $display("FAIL done_and_ready actual=1 required=0 (t=%0t)", $time);
         end
         if (after_done) begin
            chk("ready_after_done", req_ready, 1);
            chk("busy_after_done", busy, 0);
            after_done = 1'b0;
         end
         if (S) begin
            s_seen++;
            if (first_seen < 0) first_seen = cyc - acc_cyc;
         end
         if (R) begin
            r_seen++;
            if (first_seen < 0) first_seen = cyc - acc_cyc;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
               e_mon = exp_q.pop_front();
               chk("latency", cyc - acc_cyc, e_mon.lat);
               chk("err", err, e_mon.err);
               chk("s_cycles", s_seen, e_mon.s_cnt);
               chk("r_cycles", r_seen, e_mon.r_cnt);
               if (e_mon.s_cnt + e_mon.r_cnt > 0) chk("pulse_start", first_seen, 1);
            end
            after_done = 1'b1;
         end
         if (req_valid && req_ready) begin
            acc_cyc    = cyc;
            s_seen     = 0;
            r_seen     = 0;
            first_seen = -1;
         end
      end
   end

   // Issue one request; returns at posedge+1 just after the accept edge.
   task automatic send(input logic v, input exp_t e, input bit drop);
      int n = 0;
      req_valid = 1'b1;
      req_value = v;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         chk("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      if (drop) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_R"}, R, 0);
      chk({tag, "_S"}, S, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, req_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check_reset_outputs("idle");

      // Write 1 from Q=0.
      send(1'b1, mk(1'b0, 8, 4, 0), 1'b1);
      wait_idle();

      // Write 0 with latch stuck at 1: timeout, err holds.
      stuck_en  = 1'b1;
      stuck_val = 1'b1;
      send(1'b0, mk(1'b1, 15, 0, 4), 1'b1);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("err_hold", err, 1);

      // Write 1 while Q already 1.
`ifdef RS_LATCH_DRIVER_SKIP_EN
      send(1'b1, mk(1'b0, 1, 0, 0), 1'b1);
`else
      send(1'b1, mk(1'b0, 8, 4, 0), 1'b1);
`endif
      chk("err_clear_on_accept", err, 0);
      wait_idle();
      stuck_en = 1'b0;

      // Clear latch, then back-to-back 1,0,1 with req_valid held.
      send(1'b0, mk(1'b0, 8, 0, 4), 1'b1);
      wait_idle();
      send(1'b1, mk(1'b0, 8, 4, 0), 1'b0);
      send(1'b0, mk(1'b0, 8, 0, 4), 1'b0);
      send(1'b1, mk(1'b0, 8, 4, 0), 1'b1);
      wait_idle();

      // Reset during the second S cycle.
      send(1'b0, mk(1'b0, 8, 0, 4), 1'b1);
      wait_idle();
      send(1'b1, mk(1'b0, 8, 4, 0), 1'b1);
      chk("s_first_cycle", S, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("abort_ready", req_ready, 1);
      chk("abort_busy", busy, 0);

      // Normal write after the abort (latch holds 1 from the partial S pulse).
      send(1'b0, mk(1'b0, 8, 0, 4), 1'b1);
      wait_idle();

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rs_latch_driver.md
Name: rs_latch_driver

Overview:
- Synchronous initiator for a gated RS storage latch.
- Accepts single-bit write requests over a valid/ready handshake and converts each one into a clean, width-controlled S or R pulse. R and S are never both high.
- After the pulse it waits a guard gap, then checks the latch's Q readback and reports done/err.
- Sits between control logic and the latch cell: the latch is the responder, this block drives it.

Parameters:
- PULSE_W, 4, cycles R or S is held high per write (legal range 1..255).
- GAP_W, 2, cycles with R=S=0 after the pulse, before readback check (legal range 0..255).
- CHECK_TO, 8, maximum cycles in CHECK waiting for readback match (legal range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  write request present.
- req_value  in  1  value to store: 1 → pulse S, 0 → pulse R.
- req_ready  out  1  block idle and able to accept.
- R  out  1  latch reset drive, registered.
- S  out  1  latch set drive, registered.
- q_fb  in  1  latch Q readback, asynchronous to clk.
- done  out  1  one-cycle completion strobe.
- err  out  1  result of the last completed write; valid when done=1 and held until the next accept.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets:
  - state=IDLE, R=0, S=0, done=0, err=0, busy=0, req_ready=1.
  - Synchroniser flops=0, counters=0.
- q_fb passes through a 2-flop synchroniser; q_sync is the only internal use of q_fb.
- Accept occurs when req_valid & req_ready on a clk edge:
  - req_value is latched into val_r.
  - req_ready drops to 0 and busy rises to 1 on that same edge.
- IDLE:
  - On accept → PULSE and cnt=PULSE_W-1.
  - Also on that edge, S<=val_r and R<=~val_r, so the driven line is high the cycle after accept.
- PULSE:
  - Hold R/S.
  - If cnt=0 → GAP: R<=0, S<=0, cnt=GAP_W-1. If GAP_W=0, go directly to CHECK with cnt=CHECK_TO-1.
  - Otherwise cnt--.
  - Driven line is high for exactly PULSE_W cycles.
- GAP:
  - R=S=0.
  - At cnt=0 → CHECK with cnt=CHECK_TO-1; otherwise cnt--.
- CHECK:
  - Sample q_sync each cycle.
  - Match (q_sync==val_r) → DONE with err<=0.
  - Else if cnt=0 → DONE with err<=1.
  - Else cnt--.
- DONE:
  - done=1 for exactly one cycle → IDLE.
  - req_ready=1 and busy=0 from the next cycle.
- Latency:
  - Minimum accept-to-done is PULSE_W+GAP_W+2 cycles (CHECK matched on its first cycle).
  - Maximum is PULSE_W+GAP_W+CHECK_TO+1 cycles.
- Invariants:
  - R&S is never 1.
  - R and S are 0 outside PULSE.
  - done and req_ready are never high in the same cycle.
- Back-to-back requests: req_valid held high during a write is ignored until IDLE. There is no queueing; req_value is sampled only at accept.
- Reset mid-operation: R and S drop to 0 immediately (async), the in-flight write is abandoned, and no done is issued.
- A q_fb glitch during PULSE or GAP is ignored. Only CHECK evaluates the readback.

Optional Feature:
- Macro: RS_LATCH_DRIVER_SKIP_EN.
- Defined:
  - At accept, if q_sync already equals req_value, go IDLE→DONE directly.
  - No R/S pulse is generated; err=0; done follows the accept edge by 1 cycle.
- Undefined: every accepted request generates a pulse, regardless of the current latch state.

Decomposition:
- Package rs_latch_driver_pkg holds:
  - The state enum (IDLE, PULSE, GAP, CHECK, DONE; 3-bit encoding).
  - Default values for PULSE_W, GAP_W and CHECK_TO.
  - An 8-bit counter width constant.
- One natural sub-module: sync_2ff (1-bit, async active-low reset to 0), instantiated for q_fb.

Test Plan (PULSE_W=4, GAP_W=2, CHECK_TO=8; latch model with 1-cycle response unless stated):
- Reset check: apply rst_n=0 → R=0, S=0, done=0, err=0, busy=0, req_ready=1. Release and idle 10 cycles → no change.
- Write 1 from Q=0:
  - S high exactly 4 cycles starting the cycle after accept; R stays 0.
  - done pulses once at accept+8, with err=0 and req_ready=1 the following cycle.
- Write 0, latch model stuck at 1:
  - R high 4 cycles; CHECK times out after 8 cycles.
  - done with err=1 at accept+15; err holds 1 until the next accept.
- Back-to-back: req_valid held high with values 1,0,1 → three separate pulse sequences, no overlap. R&S=0 checked every cycle by assertion.
- Reset mid-PULSE: assert rst_n=0 on the 2nd S cycle → S=0 immediately, no done, req_ready=1 after release. A new write then completes normally.
- With RS_LATCH_DRIVER_SKIP_EN: write 1 while Q=1 → no S/R pulse, done at accept+1, err=0. Without the macro, the same stimulus produces a 4-cycle S pulse.
